cds_skip_accumulator: RTL

//   Sample-side counterpart of CIS_Control. It consumes the SPROCKET_PED and SPROCKET_SIG

---
 rtl/cds_skip_accumulator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cds_skip_accumulator.sv
// cds_skip_accumulator
//   Sample-side companion to CIS_Control. For each pedestal/signal strobe pair
//   in a skipping sequence it forms the correlated-double-sample difference
//   (sig - ped) and accumulates it with saturation. One signed pixel value is
//   emitted per sequence, framed by the 'running' level.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   running       sequence-active level; rise starts, fall aborts a sequence
//   sprocket_ped  pedestal strobe level (edge detected, may be held)
//   sprocket_sig  signal strobe level (edge detected, may be held)
//   adc_data      unsigned ADC sample, captured in the strobe-rise clock
//   skip_samples  ped/sig pairs per sequence (0 treated as 1), latched at start
//   pixel_data    signed sum of differences, held until next pixel
//   pixel_count   pairs accumulated into pixel_data
//   pixel_valid   one-clock pulse qualifying pixel_data/count/short
//   pixel_short   pixel ended by running fall before all pairs arrived
//   seq_err       sticky out-of-order strobe flag for current sequence
//   overflow      sticky saturation flag for current sequence
//   busy          high while waiting for pedestal or signal strobes
module cds_skip_accumulator #(
  parameter int unsigned ADC_WIDTH = 18,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        running,
  input  logic                        sprocket_ped,
  input  logic                        sprocket_sig,
  input  logic [ADC_WIDTH-1:0]        adc_data,
  input  logic [9:0]                  skip_samples,
  output logic signed [ACC_WIDTH-1:0] pixel_data,
  output logic [9:0]                  pixel_count,
  output logic                        pixel_valid,
  output logic                        pixel_short,
  output logic                        seq_err,
  output logic                        overflow,
  output logic                        busy
);

  localparam int unsigned DW = ADC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_PED, S_WAIT_SIG, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic                   ped_prev_q, sig_prev_q, run_prev_q;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [9:0]             n_q, n_d;
  logic [ADC_WIDTH-1:0]   ped_reg_q, ped_reg_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic                   short_q, short_d;
  logic [ACC_WIDTH-1:0]   pdata_q, pdata_d;
  logic [9:0]             pcount_q, pcount_d;
  logic                   pvalid_q, pvalid_d;

  logic                   ped_rise, sig_rise, run_rise;
  logic [DW-1:0]          diff;
  logic [ACC_WIDTH:0]     sum_ext;
  logic [ACC_WIDTH-1:0]   sat_sum;
  logic                   sat_hit;

  assign ped_rise = sprocket_ped & ~ped_prev_q;
  assign sig_rise = sprocket_sig & ~sig_prev_q;
  assign run_rise = running & ~run_prev_q;

  // Both operands zero-extended by one bit so the difference is a proper
  // (ADC_WIDTH+1)-bit two's complement value.
  assign diff = {1'b0, adc_data} - {1'b0, ped_reg_q};

  // One guard bit above the accumulator: a disagreement between the guard
  // bit and the accumulator MSB means the true sum left the signed range.
  always_comb begin
    sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {{(ACC_WIDTH + 1 - DW){diff[DW-1]}}, diff};
    sat_hit = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    sat_sum = sum_ext[ACC_WIDTH-1:0];
    if (sat_hit) begin
      sat_sum = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    ped_reg_d = ped_reg_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    short_d   = short_q;
    pdata_d   = pdata_q;
    pcount_d  = pcount_q;
    pvalid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          short_d = 1'b0;
          n_d     = (skip_samples == 10'd0) ? 10'd1 : skip_samples;
          state_d = S_WAIT_PED;
        end
      end
      S_WAIT_PED: begin
        // An abort takes priority over any strobe in the same clock.
        if (!running) begin
          short_d = 1'b1;
          state_d = S_DONE;
        end else if (ped_rise && sig_rise) begin
          err_d = 1'b1;
        end else if (ped_rise) begin
          ped_reg_d = adc_data;
          state_d   = S_WAIT_SIG;
        end else if (sig_rise) begin
          err_d = 1'b1;
        end
      end
      S_WAIT_SIG: begin
        if (!running) begin
          short_d = 1'b1;
          state_d = S_DONE;
        end else if (ped_rise && sig_rise) begin
          err_d = 1'b1;
        end else if (sig_rise) begin
          acc_d   = sat_sum;
          ovf_d   = ovf_q | sat_hit;
          cnt_d   = cnt_q + 10'd1;
          state_d = (cnt_q + 10'd1 == n_q) ? S_DONE : S_WAIT_PED;
        end else if (ped_rise) begin
          err_d     = 1'b1;
          ped_reg_d = adc_data;
        end
      end
      S_DONE: begin
        pdata_d  = acc_q;
        pcount_d = cnt_q;
        pvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ped_prev_q <= 1'b0;
      sig_prev_q <= 1'b0;
      run_prev_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      ped_reg_q  <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
      pdata_q    <= '0;
      pcount_q   <= '0;
      pvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_prev_q <= sprocket_ped;
      sig_prev_q <= sprocket_sig;
      run_prev_q <= running;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      ped_reg_q  <= ped_reg_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
      pdata_q    <= pdata_d;
      pcount_q   <= pcount_d;
      pvalid_q   <= pvalid_d;
    end
  end

  assign pixel_data  = pdata_q;
  assign pixel_count = pcount_q;
  assign pixel_valid = pvalid_q;
  assign pixel_short = short_q;
  assign seq_err     = err_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == S_WAIT_PED) || (state_q == S_WAIT_SIG);

endmodule
